// File: rtl/arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, memory access
// length codes and requester identifiers.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Length codes match the memory's own encoding, so they pass through as-is.
    typedef enum logic [1:0] {
        LEN_NONE = 2'b00,
        LEN_B    = 2'b01,
        LEN_H    = 2'b10,
        LEN_W    = 2'b11
    } mem_len_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    localparam int CNT_W = 8;

endpackage

// File: rtl/arb_timeout_counter.sv
// Saturating cycle counter used to bound how long an access may wait for
// mem_ack. 'expired' flags the last permitted BUSY cycle.
module arb_timeout_counter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic SYS_clk,
    input  logic SYS_reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count;

    // Count BUSY cycles; clear on a new grant and stick at the maximum.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction
// fetch and load/store. Each grant runs one req/ack transaction, ending in a
// one-cycle ready pulse to the granted requester (with access_err on timeout).
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 16,
    parameter int FETCH_FIRST = 0
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [1:0]        data_len,
    input  logic              data_signed,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ready,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_len,
    output logic              mem_signed,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              access_err,
    output logic              busy
);

    // Reset value chosen so the first simultaneous request goes the other way.
    localparam grant_t GNT_RESET = (FETCH_FIRST != 0) ? GNT_DATA : GNT_FETCH;

    arb_state_t        state, state_nxt;
    grant_t            last_grant, grant_nxt;
    logic              start;
    logic              done;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              tmo_expired;

    arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
        .SYS_clk    (SYS_clk),
        .SYS_reset_n(SYS_reset_n),
        .clear      (start),
        .enable     (state == ST_BUSY),
        .expired    (tmo_expired)
    );

    // State and grant registers.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state      <= ST_IDLE;
            last_grant <= GNT_RESET;
        end else begin
            state      <= state_nxt;
            last_grant <= grant_nxt;
        end
    end

    // Next state, grant selection and completion result.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        grant_nxt = last_grant;
        start     = 1'b0;
        done      = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fetch_req || data_req) begin
                    start = 1'b1;
                    if (fetch_req && data_req) begin
                        grant_nxt = (last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
                    end else if (data_req) begin
                        grant_nxt = GNT_DATA;
                    end else begin
                        grant_nxt = GNT_FETCH;
                    end
                    if ((grant_nxt == GNT_DATA) && (data_len == LEN_NONE)) begin
                        // Nothing to move: answer immediately with zero data.
                        state_nxt = ST_RESP;
                        done      = 1'b1;
                    end else begin
                        state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    state_nxt = ST_RESP;
                    done      = 1'b1;
                    rsp_rdata = mem_we ? '0 : mem_rdata;
                end else if (tmo_expired) begin
                    state_nxt = ST_RESP;
                    done      = 1'b1;
                    rsp_err   = 1'b1;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Latch the granted request toward memory and deliver completions.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            mem_we      <= 1'b0;
            mem_len     <= LEN_NONE;
            mem_signed  <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            fetch_ready <= 1'b0;
            fetch_rdata <= '0;
            data_ready  <= 1'b0;
            data_rdata  <= '0;
            access_err  <= 1'b0;
        end else begin
            fetch_ready <= 1'b0;
            data_ready  <= 1'b0;
            access_err  <= 1'b0;
            if (start) begin
                if (grant_nxt == GNT_DATA) begin
                    mem_we     <= data_we;
                    mem_len    <= data_len;
                    mem_signed <= data_signed;
                    mem_addr   <= data_addr;
                    mem_wdata  <= data_wdata;
                end else begin
                    mem_we     <= 1'b0;
                    mem_len    <= LEN_W;
                    mem_signed <= 1'b0;
                    mem_addr   <= fetch_addr;
                    mem_wdata  <= '0;
                end
            end
            if (done) begin
                access_err <= rsp_err;
                if (grant_nxt == GNT_DATA) begin
                    data_ready <= 1'b1;
                    data_rdata <= rsp_rdata;
                end else begin
                    fetch_ready <= 1'b1;
                    fetch_rdata <= rsp_rdata;
                end
            end
        end
    end

    assign mem_req = (state == ST_BUSY);
    assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized transactions, all compared against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              SYS_clk = 1'b0;
    logic              SYS_reset_n = 1'b0;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_ready;
    logic [DATA_W-1:0] fetch_rdata;
    logic              data_req = 1'b0;
    logic              data_we = 1'b0;
    logic [1:0]        data_len = 2'b00;
    logic              data_signed = 1'b0;
    logic [ADDR_W-1:0] data_addr = '0;
    logic [DATA_W-1:0] data_wdata = '0;
    logic              data_ready;
    logic [DATA_W-1:0] data_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic              mem_signed;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              access_err;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model state: who won the last grant, and the value
    // each requester's rdata register should currently hold.
    bit                m_last_data = 1'b0;
    logic [DATA_W-1:0] m_frd = '0;
    logic [DATA_W-1:0] m_drd = '0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .FETCH_FIRST(0)
    ) dut (
        .SYS_clk    (SYS_clk),
        .SYS_reset_n(SYS_reset_n),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .fetch_rdata(fetch_rdata),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_len   (data_len),
        .data_signed(data_signed),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_ready (data_ready),
        .data_rdata (data_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_len    (mem_len),
        .mem_signed (mem_signed),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .access_err (access_err),
        .busy       (busy)
    );

    always #5 SYS_clk = ~SYS_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction: present the requests before an IDLE edge, play the
    // memory with 'w' wait cycles (-1 = never ack), and check the outcome
    // derived from the arbitration rules. Returns with the DUT back in IDLE.
    task automatic txn(input string tag, input bit f, input bit d,
                       input logic [ADDR_W-1:0] faddr, input bit we, input logic [1:0] len,
                       input bit sgn, input logic [ADDR_W-1:0] daddr,
                       input logic [DATA_W-1:0] wd, input int w,
                       input logic [DATA_W-1:0] ack_data, input bit keep);
        bit                gnt_data;
        bit                nomem;
        bit                acked;
        bit                exp_err;
        int                exp_mem;
        int                mem_cnt;
        bit                got;
        logic [DATA_W-1:0] exp_rd;
        logic [63:0]       exp_fields;

        fetch_req   = f;
        fetch_addr  = faddr;
        data_req    = d;
        data_we     = we;
        data_len    = len;
        data_signed = sgn;
        data_addr   = daddr;
        data_wdata  = wd;

        gnt_data    = (f && d) ? !m_last_data : d;
        m_last_data = gnt_data;
        nomem       = gnt_data && (len == 2'b00);
        acked       = !nomem && (w >= 0) && (w + 1 <= TIMEOUT);
        exp_mem     = nomem ? 0 : (acked ? w + 1 : TIMEOUT);
        exp_err     = !nomem && !acked;
        exp_rd      = (acked && !(gnt_data && we)) ? ack_data : '0;
        exp_fields  = gnt_data ? 64'({we, len, sgn, daddr}) : 64'({1'b0, 2'b11, 1'b0, faddr});

        @(posedge SYS_clk);
        mem_cnt = 0;
        got     = 1'b0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge SYS_clk);
            if (fetch_ready || data_ready) begin
                got = 1'b1;
                if (gnt_data) m_drd = exp_rd;
                else          m_frd = exp_rd;
                check({tag, " mem_cycles"}, 64'(mem_cnt), 64'(exp_mem));
                check({tag, " ready_pair"}, 64'({fetch_ready, data_ready}), 64'({!gnt_data, gnt_data}));
                check({tag, " fetch_rdata"}, 64'(fetch_rdata), 64'(m_frd));
                check({tag, " data_rdata"}, 64'(data_rdata), 64'(m_drd));
                check({tag, " access_err"}, 64'(access_err), 64'(exp_err));
                check({tag, " resp_busy_memreq"}, 64'({busy, mem_req}), 64'(2'b10));
                mem_ack = 1'b0;
                if (!keep) begin
                    fetch_req = 1'b0;
                    data_req  = 1'b0;
                end
            end else begin
                check({tag, " busy_wait"}, 64'(busy), 64'(1));
                if (mem_req) begin
                    mem_cnt++;
                    check({tag, " mem_fields"}, 64'({mem_we, mem_len, mem_signed, mem_addr}), exp_fields);
                    if (gnt_data && we) check({tag, " mem_wdata"}, 64'(mem_wdata), 64'(wd));
                    mem_ack   = (w >= 0) && (mem_cnt == w + 1);
                    mem_rdata = mem_ack ? ack_data : $urandom;
                end else begin
                    mem_ack = 1'b0;
                end
            end
        end
        check({tag, " ready_seen"}, 64'(got), 64'(1));
        @(posedge SYS_clk);
        @(negedge SYS_clk);
        check({tag, " idle_after"}, 64'({busy, mem_req, fetch_ready, data_ready, access_err}), 64'(0));
        check({tag, " rdata_hold"}, {fetch_rdata, data_rdata}, {m_frd, m_drd});
    endtask

    initial begin
        bit                rf;
        bit                rd;
        int                rw;
        int                rsel;
        logic [1:0]        rlen;

        // Reset state: everything visible is zero.
        @(negedge SYS_clk);
        @(negedge SYS_clk);
        check("reset_outputs",
              64'({fetch_ready, data_ready, mem_req, mem_we, mem_len, mem_signed, access_err, busy}),
              64'(0));
        check("reset_rdata", {fetch_rdata, data_rdata}, 64'(0));
        check("reset_mem_bus", {mem_addr, mem_wdata}, 64'(0));
        SYS_reset_n = 1'b1;
        @(negedge SYS_clk);

        // Both requesters held: data wins first, then strict alternation.
        for (int i = 0; i < 4; i++) begin
            txn("rr", 1'b1, 1'b1, 32'h100 + 32'(4 * i), 1'b0, 2'b11, 1'b0,
                32'h200 + 32'(4 * i), 32'h0, 0, 32'hA000_0000 + 32'(i), 1'b1);
        end

        // Fetch alone, zero-wait memory.
        txn("fetch", 1'b1, 1'b0, 32'h10, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 0, 32'h00C0_0613, 1'b0);

        // Byte store, ack arrives together with the last permitted cycle.
        txn("store", 1'b0, 1'b1, 32'h0, 1'b1, 2'b01, 1'b0, 32'h21, 32'hAB, 3, 32'hFFFF_FFFF, 1'b0);

        // Signed halfword load with one wait state.
        txn("load_h", 1'b0, 1'b1, 32'h0, 1'b0, 2'b10, 1'b1, 32'h42, 32'h0, 1, 32'hFFFF_8001, 1'b0);

        // No ack at all: timeout, then a late ack must be ignored.
        txn("timeout", 1'b0, 1'b1, 32'h0, 1'b0, 2'b11, 1'b0, 32'h80, 32'h0, -1, 32'h1234_5678, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge SYS_clk);
            check("late_ack_ignored",
                  64'({fetch_ready, data_ready, busy, mem_req, access_err}), 64'(0));
        end
        check("late_ack_rdata", {fetch_rdata, data_rdata}, {m_frd, m_drd});
        mem_ack = 1'b0;

        // Length "none": no memory access, immediate response.
        txn("len_none", 1'b0, 1'b1, 32'h0, 1'b0, 2'b00, 1'b0, 32'h44, 32'h0, 0, 32'h5555_5555, 1'b0);

        // Reset in the middle of an access.
        fetch_req  = 1'b1;
        fetch_addr = 32'h300;
        @(posedge SYS_clk);
        @(negedge SYS_clk);
        check("pre_reset_busy", 64'({busy, mem_req}), 64'(2'b11));
        #2 SYS_reset_n = 1'b0;
        #1 check("reset_midaccess", 64'({busy, mem_req, fetch_ready, data_ready}), 64'(0));
        fetch_req = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        @(negedge SYS_clk);
        SYS_reset_n = 1'b1;
        m_last_data = 1'b0;
        m_frd       = '0;
        m_drd       = '0;
        @(negedge SYS_clk);
        check("after_reset_quiet", 64'({busy, mem_req, fetch_ready, data_ready, access_err}), 64'(0));
        check("after_reset_rdata", {fetch_rdata, data_rdata}, 64'(0));
        mem_ack = 1'b0;
        txn("fetch_after_reset", 1'b1, 1'b0, 32'h304, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 2,
            32'h0000_0013, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            rf   = 1'($urandom_range(0, 1));
            rd   = 1'($urandom_range(0, 1));
            if (!rf && !rd) rf = 1'b1;
            rsel = int'($urandom_range(0, 7));
            rw   = (rsel == 7) ? -1 : rsel;
            rlen = 2'($urandom_range(0, 3));
            txn("rand", rf, rd, $urandom, 1'($urandom_range(0, 1)), rlen,
                1'($urandom_range(0, 1)), $urandom, $urandom, rw, $urandom, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
